// File: rtl/regsel_sequencer_pkg.sv
// Shared command codes, source-select codes, FSM states and control word for
// the regSel register-transfer sequencer.
package regsel_sequencer_pkg;

   localparam int unsigned CMD_W    = 3;
   localparam int unsigned REG_W    = 3;
   localparam int unsigned OE_SRC_W = 2;

   localparam logic [CMD_W-1:0] CMD_MOV   = 3'd0;
   localparam logic [CMD_W-1:0] CMD_ALU   = 3'd1;
   localparam logic [CMD_W-1:0] CMD_SWAP  = 3'd2;
   localparam logic [CMD_W-1:0] CMD_INCPC = 3'd3;

   localparam logic [REG_W-1:0] PC_REG_DEF = 3'd7;

   localparam logic [OE_SRC_W-1:0] OE_SRC_USEQ = 2'b00;
   localparam logic [OE_SRC_W-1:0] OE_SRC_OP0  = 2'b01;
   localparam logic [OE_SRC_W-1:0] OE_SRC_OP1  = 2'b10;
   localparam logic [OE_SRC_W-1:0] OE_SRC_OP2  = 2'b11;

   localparam logic LD_SRC_USEQ = 1'b0;
   localparam logic LD_SRC_OP0  = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_MOV1,
      ST_ALU1,
      ST_ALU2,
      ST_ALU3,
      ST_SWP1,
      ST_SWP2,
      ST_SWP3,
      ST_INC1,
      ST_INC2,
      ST_ERR
   } state_e;

   typedef struct packed {
      logic                oe;
      logic                load;
      logic [OE_SRC_W-1:0] oe_src;
      logic                load_src;
      logic [REG_W-1:0]    useq_oe;
      logic [REG_W-1:0]    useq_load;
      logic                alu_load_a;
      logic                alu_load_b;
      logic                alu_oe;
      logic                alu_inc;
      logic                tmp_load;
      logic                tmp_oe;
      logic                busy;
      logic                done;
      logic                illegal;
   } ctrl_t;

   // First step entered when a command is accepted; unsupported codes go to ERR.
   function automatic state_e first_step(input logic [CMD_W-1:0] cmd);
      state_e st;
      case (cmd)
         CMD_MOV:   st = ST_MOV1;
         CMD_ALU:   st = ST_ALU1;
         CMD_SWAP:  st = ST_SWP1;
         CMD_INCPC: st = ST_INC1;
         default:   st = ST_ERR;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/regsel_sequencer_decode.sv
// Combinational state -> control-word table for the regSel sequencer.
// Selects stay 0 whenever their enable is low.
module regsel_sequencer_decode
   import regsel_sequencer_pkg::*;
#(
   parameter logic [REG_W-1:0] PC_REG = PC_REG_DEF
) (
   input  state_e           state,
   input  logic [REG_W-1:0] swap_dst,
   output ctrl_t            ctrl_c
);

   always_comb begin
      ctrl_c      = '0;
      ctrl_c.busy = (state != ST_IDLE);
      case (state)
         ST_MOV1: begin
            ctrl_c.oe       = 1'b1;
            ctrl_c.oe_src   = OE_SRC_OP1;
            ctrl_c.load     = 1'b1;
            ctrl_c.load_src = LD_SRC_OP0;
            ctrl_c.done     = 1'b1;
         end
         ST_ALU1: begin
            ctrl_c.oe         = 1'b1;
            ctrl_c.oe_src     = OE_SRC_OP1;
            ctrl_c.alu_load_a = 1'b1;
         end
         ST_ALU2: begin
            ctrl_c.oe         = 1'b1;
            ctrl_c.oe_src     = OE_SRC_OP2;
            ctrl_c.alu_load_b = 1'b1;
         end
         ST_ALU3: begin
            ctrl_c.alu_oe   = 1'b1;
            ctrl_c.load     = 1'b1;
            ctrl_c.load_src = LD_SRC_OP0;
            ctrl_c.done     = 1'b1;
         end
         ST_SWP1: begin
            ctrl_c.oe       = 1'b1;
            ctrl_c.oe_src   = OE_SRC_OP0;
            ctrl_c.tmp_load = 1'b1;
         end
         ST_SWP2: begin
            ctrl_c.oe       = 1'b1;
            ctrl_c.oe_src   = OE_SRC_OP1;
            ctrl_c.load     = 1'b1;
            ctrl_c.load_src = LD_SRC_OP0;
         end
         // op1 may have moved on since accept, so the latched copy addresses the load
         ST_SWP3: begin
            ctrl_c.tmp_oe    = 1'b1;
            ctrl_c.load      = 1'b1;
            ctrl_c.load_src  = LD_SRC_USEQ;
            ctrl_c.useq_load = swap_dst;
            ctrl_c.done      = 1'b1;
         end
         ST_INC1: begin
            ctrl_c.oe         = 1'b1;
            ctrl_c.oe_src     = OE_SRC_USEQ;
            ctrl_c.useq_oe    = PC_REG;
            ctrl_c.alu_load_a = 1'b1;
         end
         ST_INC2: begin
            ctrl_c.alu_oe    = 1'b1;
            ctrl_c.alu_inc   = 1'b1;
            ctrl_c.load      = 1'b1;
            ctrl_c.load_src  = LD_SRC_USEQ;
            ctrl_c.useq_load = PC_REG;
            ctrl_c.done      = 1'b1;
         end
         ST_ERR: begin
            ctrl_c.illegal = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/regsel_sequencer.sv
// Multi-cycle register-transfer sequencer for regSel: accepts a command on
// start in IDLE and steps the data bus one transfer per cycle.
module regsel_sequencer
   import regsel_sequencer_pkg::*;
#(
   parameter logic [REG_W-1:0] PC_REG = PC_REG_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [CMD_W-1:0]    cmd,
   input  logic [REG_W-1:0]    op1,
   output logic                oe,
   output logic                load,
   output logic [OE_SRC_W-1:0] oeSourceSel,
   output logic                loadSourceSel,
   output logic [REG_W-1:0]    useqRegSelOe,
   output logic [REG_W-1:0]    useqRegSelLoad,
   output logic                aluLoadA,
   output logic                aluLoadB,
   output logic                aluOe,
   output logic                aluInc,
   output logic                tmpLoad,
   output logic                tmpOe,
   output logic                busy,
   output logic                done,
   output logic                illegal
);

   state_e           state_q, state_d;
   logic [REG_W-1:0] swap_dst_q, swap_dst_d;
   ctrl_t            ctrl_q, ctrl_d;

   // Next-state: each step lasts one cycle; cmd and op1 only sampled on accept.
   always_comb begin
      state_d    = state_q;
      swap_dst_d = swap_dst_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = first_step(cmd);
               swap_dst_d = op1;
            end
         end
         ST_ALU1: state_d = ST_ALU2;
         ST_ALU2: state_d = ST_ALU3;
         ST_SWP1: state_d = ST_SWP2;
         ST_SWP2: state_d = ST_SWP3;
         ST_INC1: state_d = ST_INC2;
         default: state_d = ST_IDLE;
      endcase
   end

   // Control word is decoded from the next state and registered alongside it.
   regsel_sequencer_decode #(
      .PC_REG (PC_REG)
   ) u_decode (
      .state    (state_d),
      .swap_dst (swap_dst_d),
      .ctrl_c   (ctrl_d)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         swap_dst_q <= '0;
         ctrl_q     <= '0;
      end else begin
         state_q    <= state_d;
         swap_dst_q <= swap_dst_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign oe             = ctrl_q.oe;
   assign load           = ctrl_q.load;
   assign oeSourceSel    = ctrl_q.oe_src;
   assign loadSourceSel  = ctrl_q.load_src;
   assign useqRegSelOe   = ctrl_q.useq_oe;
   assign useqRegSelLoad = ctrl_q.useq_load;
   assign aluLoadA       = ctrl_q.alu_load_a;
   assign aluLoadB       = ctrl_q.alu_load_b;
   assign aluOe          = ctrl_q.alu_oe;
   assign aluInc         = ctrl_q.alu_inc;
   assign tmpLoad        = ctrl_q.tmp_load;
   assign tmpOe          = ctrl_q.tmp_oe;
   assign busy           = ctrl_q.busy;
   assign done           = ctrl_q.done;
   assign illegal        = ctrl_q.illegal;

endmodule
